// File: rtl/tft_timing_ctrl.sv
// Raster sequencer for the TFT/DVI path: generates HSYNC/VSYNC/DE and registered RGB
// from the pixel FIFO, held off until the Chrontel configuration reports done.
module tft_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        TFT_Clk,
  input  logic        Reset_n,
  input  logic        EN,
  input  logic        I2C_done,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_VALID,
  output logic        PIX_REQ,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic        FRAME_START,
  output logic        UNDERFLOW,
  input  logic        UNDERFLOW_CLR
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic go;
  logic h_wrap;
  logic frame_end;
  logic active;
  logic hs;
  logic vs;
  logic scanning;

  assign go        = EN && I2C_done;
  assign h_wrap    = (h_cnt == H_LAST);
  assign frame_end = h_wrap && (v_cnt == V_LAST);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs        = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs        = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign scanning  = (state != IDLE);

  // Pop is combinational so the FIFO head is consumed in the same cycle it is registered.
  assign PIX_REQ = scanning && active;

  // NOTE: all state and output registers use non-blocking assignments so every
  // right-hand side sees pre-edge values and the outputs stay aligned to the counters.
  always_ff @(posedge TFT_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      DE          <= 1'b0;
      RED         <= '0;
      GREEN       <= '0;
      BLUE        <= '0;
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (go) state <= RUN;
        RUN:     if (!go) state <= DRAIN;
        // Re-enabling at any point, including the final cycle, continues without a frame break.
        DRAIN: begin
          if (go)             state <= RUN;
          else if (frame_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (!scanning) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      HSYNC       <= ~(hs && scanning);
      VSYNC       <= ~(vs && scanning);
      DE          <= PIX_REQ;
      FRAME_START <= PIX_REQ && (h_cnt == '0) && (v_cnt == '0);
      {RED, GREEN, BLUE} <= (PIX_REQ && PIX_VALID) ? PIX_DATA : 24'h0;

      // A new underflow outranks a simultaneous clear so no event is lost.
      if (PIX_REQ && !PIX_VALID) UNDERFLOW <= 1'b1;
      else if (UNDERFLOW_CLR)    UNDERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tft_timing_ctrl.sv
// Scoreboard bench for tft_timing_ctrl on a reduced 16x8 raster: a frame-position
// reference model predicts every cycle, a monitor compares registered outputs.
module tb_tft_timing_ctrl;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT    = HA + HFP + HSW + HBP;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        i2c_done = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic        pix_req, hsync, vsync, de, frame_start, underflow;
  logic [7:0]  red, green, blue;

  tft_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .TFT_Clk      (clk),
    .Reset_n      (rst_n),
    .EN           (en),
    .I2C_done     (i2c_done),
    .PIX_DATA     (pix_data),
    .PIX_VALID    (pix_valid),
    .PIX_REQ      (pix_req),
    .HSYNC        (hsync),
    .VSYNC        (vsync),
    .DE           (de),
    .RED          (red),
    .GREEN        (green),
    .BLUE         (blue),
    .FRAME_START  (frame_start),
    .UNDERFLOW    (underflow),
    .UNDERFLOW_CLR(underflow_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raster position within the frame and a running flag.
  bit          m_run = 0;
  int          m_t = 0;
  bit          m_prev_go = 0;
  bit          exp_de = 0, exp_hs_n = 1, exp_vs_n = 1, exp_fs = 0, exp_uf = 0;
  logic [23:0] pix_q[$];
  int          de_total = 0;
  bit          geom_on = 0;

  function automatic bit in_active(int t);
    return ((t % HT) < HA) && ((t / HT) < VA);
  endfunction

  function automatic bit in_hs(int t);
    int h = t % HT;
    return (h >= HA + HFP) && (h < HA + HFP + HSW);
  endfunction

  function automatic bit in_vs(int t);
    int v = t / HT;
    return (v >= VA + VFP) && (v < VA + VFP + VSW);
  endfunction

  function automatic logic [23:0] pixel_index(int t);
    return 24'((t / HT) * HA + (t % HT));
  endfunction

  // One pixel-clock cycle: check the pop, drive inputs, predict outputs after the next edge.
  task automatic cycle(input bit e, input bit d, input bit v, input bit c, input logic [23:0] data);
    bit go, req;
    @(negedge clk);
    req = m_run && in_active(m_t);
    check("pix_req", pix_req, req);
    en = e; i2c_done = d; pix_valid = v; underflow_clr = c; pix_data = data;
    go       = e && d;
    exp_de   = req;
    exp_hs_n = !(m_run && in_hs(m_t));
    exp_vs_n = !(m_run && in_vs(m_t));
    exp_fs   = req && (m_t == 0);
    if (req) pix_q.push_back(v ? data : 24'h0);
    if (req && !v) exp_uf = 1;
    else if (c)    exp_uf = 0;
    if (!m_run) begin
      m_run = go;
      m_t   = 0;
    end else if (m_t == FRAME - 1) begin
      m_t = 0;
      // The raster stops at a frame end only if the enable was already gone a cycle earlier.
      if (!go && !m_prev_go) m_run = 0;
    end else begin
      m_t++;
    end
    m_prev_go = go;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < FRAME && m_t != target; i++) cycle(1, 1, 1, 0, 24'($urandom));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    check("pix_req_pre_reset", pix_req, m_run && in_active(m_t));
    #1 rst_n = 1'b0;
    #1;
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 0);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_underflow", underflow, 0);
    check("rst_pix_req", pix_req, 0);
    #1 rst_n = 1'b1;
    m_run = 0; m_t = 0; m_prev_go = 0;
    exp_de = 0; exp_hs_n = 1; exp_vs_n = 1; exp_fs = 0; exp_uf = 0;
    pix_q.delete();
    en = 1'b0; i2c_done = 1'b1; pix_valid = 1'b1; underflow_clr = 1'b0;
  endtask

  initial begin : monitor
    logic [23:0] exp_px;
    int cyc = 0, last_fs = 0, de_cnt = 0;
    bit fs_seen = 0;
    forever begin
      settle();
      cyc++;
      check("de", de, exp_de);
      check("hsync", hsync, exp_hs_n);
      check("vsync", vsync, exp_vs_n);
      check("frame_start", frame_start, exp_fs);
      check("underflow", underflow, exp_uf);
      if (de) begin
        check("queue_has_pixel", 32'(pix_q.size() != 0), 1);
        if (pix_q.size() != 0) begin
          exp_px = pix_q.pop_front();
          check("rgb", {red, green, blue}, exp_px);
        end
      end else begin
        check("rgb_blank", {red, green, blue}, 0);
      end
      if (!geom_on) begin
        fs_seen = 0;
      end else if (frame_start) begin
        if (fs_seen) begin
          check("frame_period", cyc - last_fs, FRAME);
          check("pops_per_frame", de_cnt, HA * VA);
        end
        fs_seen = 1;
        last_fs = cyc;
        de_cnt  = 0;
      end
      if (de) begin
        de_cnt++;
        de_total++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    int snap;
    bit e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hold-off: enabled but configuration not done.
    repeat (200) cycle(1, 0, 1, 0, 24'($urandom));
    check("holdoff_de", de, 0);
    check("holdoff_hsync", hsync, 1);
    check("holdoff_vsync", vsync, 1);

    // Start latency: first DE two edges after I2C_done is sampled.
    cycle(1, 1, 1, 0, pixel_index(m_t));
    cycle(1, 1, 1, 0, pixel_index(m_t));
    check("de_before_latency", de, 0);
    settle();
    check("first_de", de, 1);
    check("first_frame_start", frame_start, 1);

    // Raster geometry with an incrementing pattern.
    geom_on = 1;
    repeat (4 * FRAME) cycle(1, 1, 1, 0, pixel_index(m_t));
    geom_on = 0;

    // Underflow on pixel 5 of line 2, then clear-vs-set and clean clear.
    run_until(0);
    for (int i = 0; i < FRAME; i++) cycle(1, 1, (m_t != 2 * HT + 5), 0, 24'($urandom));
    check("underflow_sticky", underflow, 1);
    run_until(HT + 3);
    cycle(1, 1, 0, 1, 24'($urandom));
    settle();
    check("underflow_set_wins", underflow, 1);
    cycle(1, 1, 1, 1, 24'($urandom));
    settle();
    check("underflow_cleared", underflow, 0);

    // Graceful stop: EN drops mid line 1, the frame completes, then idle.
    run_until(0);
    snap = de_total;
    for (int i = 0; i < FRAME + 40; i++) cycle(i < HT + 4, 1, 1, 0, 24'($urandom));
    check("drain_pops", de_total - snap, HA * VA);
    check("idle_hsync", hsync, 1);
    check("idle_vsync", vsync, 1);
    check("idle_de", de, 0);

    // EN drops and returns before the final wrap: no frame break.
    geom_on = 1;
    for (int i = 0; i < 3 * FRAME + 8; i++)
      cycle(!(i >= HT + 4 && i < 5 * HT), 1, 1, 0, pixel_index(m_t));
    geom_on = 0;

    // Asynchronous reset during active video, then stays idle until re-enabled.
    run_until(HT + 3);
    reset_pulse();
    repeat (50) cycle(0, 1, 1, 0, 24'($urandom));
    check("post_reset_de", de, 0);
    check("post_reset_hsync", hsync, 1);

    // Randomized traffic: enable/config glitches, FIFO bubbles, random clears.
    e = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 249) == 0) e = !e;
      cycle(e, $urandom_range(0, 399) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 15) == 0, 24'($urandom));
    end

    // Stop and let the last frame drain.
    repeat (2 * FRAME + 4) cycle(0, 1, 1, 0, 24'($urandom));
    settle();
    check("queue_drained", pix_q.size(), 0);
    check("final_de", de, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
